// File: rtl/serial_adder.sv
// Sequential adder/subtractor that processes BITS_PER_CYCLE bits per clock, LSB slice first,
// with the carry held between slices and a start/busy/done handshake.
module serial_adder #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

  generate
    if (WIDTH < 1 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
      $fatal(1, "serial_adder: WIDTH must be a positive multiple of BITS_PER_CYCLE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state, state_nxt;
  logic                      accept;
  logic                      last_slice;
  logic [WIDTH-1:0]          a_sh, b_sh;
  logic [WIDTH-1:0]          r_sh, r_nxt;
  logic [WIDTH-1:0]          slice_ext;
  logic [BITS_PER_CYCLE-1:0] slice_sum;
  logic [BITS_PER_CYCLE:0]   rc;
  logic                      carry;
  logic [CNT_W-1:0]          cnt;

  // Next-state logic; start is only honoured outside RUN
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    last_slice = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_SLICE) begin
          last_slice = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // One slice worth of full-adder ripple; rc[i] is the carry into bit i of the slice
  always_comb begin
    rc        = '0;
    slice_sum = '0;
    rc[0]     = carry;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      slice_sum[i] = a_sh[i] ^ b_sh[i] ^ rc[i];
      rc[i+1]      = (a_sh[i] & b_sh[i]) | (rc[i] & (a_sh[i] ^ b_sh[i]));
    end
    slice_ext                      = '0;
    slice_ext[BITS_PER_CYCLE-1:0]  = slice_sum;
    r_nxt = (r_sh >> BITS_PER_CYCLE) | (slice_ext << (WIDTH - BITS_PER_CYCLE));
  end

  // Subtract is folded into the captured operand and carry: a + ~b + ~ci == a - b - ci
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= sub ? ~b : b;
      carry <= ci ^ sub;
      r_sh  <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> BITS_PER_CYCLE;
      b_sh  <= b_sh >> BITS_PER_CYCLE;
      carry <= rc[BITS_PER_CYCLE];
      r_sh  <= r_nxt;
      cnt   <= cnt + 1'b1;
      if (last_slice) begin
        s   <= r_nxt;
        co  <= rc[BITS_PER_CYCLE];
        ovf <= rc[BITS_PER_CYCLE-1] ^ rc[BITS_PER_CYCLE];
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit/1-bit-per-cycle instance and a
// 16-bit/4-bits-per-cycle instance, with hand-computed expected results.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8-bit instance, one bit per cycle
  logic       rst8, start8, sub8, ci8;
  logic [7:0] a8, b8;
  logic       busy8, done8, co8, ovf8;
  logic [7:0] s8;

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .sub(sub8), .a(a8), .b(b8), .ci(ci8),
    .busy(busy8), .done(done8), .s(s8), .co(co8), .ovf(ovf8)
  );

  // 16-bit instance, four bits per cycle
  logic        rst16, start16, sub16, ci16;
  logic [15:0] a16, b16;
  logic        busy16, done16, co16, ovf16;
  logic [15:0] s16;

  serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
    .clk(clk), .rst(rst16), .start(start16), .sub(sub16), .a(a16), .b(b16), .ci(ci16),
    .busy(busy16), .done(done16), .s(s16), .co(co16), .ovf(ovf16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge: present a request for one cycle, return at the next negedge
  task automatic launch8(input logic sb, input logic [7:0] aa, input logic [7:0] bb, input logic cc);
    start8 = 1'b1; sub8 = sb; a8 = aa; b8 = bb; ci8 = cc;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Counts edges from the accepting edge until done; returns at the negedge where done is high
  task automatic wait_done8(input string tag, input int n_exp);
    int cycles = 0;
    while (!done8 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_lat"}, cycles, n_exp);
  endtask

  task automatic op8(input string tag, input logic sb, input logic [7:0] aa, input logic [7:0] bb,
                     input logic cc, input logic [7:0] es, input logic eco, input logic eovf);
    launch8(sb, aa, bb, cc);
    check({tag, "_busy"}, busy8, 1'b1);
    wait_done8(tag, 8);
    check({tag, "_s"}, s8, es);
    check({tag, "_co"}, co8, eco);
    check({tag, "_ovf"}, ovf8, eovf);
    check({tag, "_busy_done"}, busy8, 1'b0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done8, 1'b0);
  endtask

  initial begin
    rst8 = 1'b1; start8 = 1'b1; sub8 = 1'b0; a8 = 8'hFF; b8 = 8'h00; ci8 = 1'b0;
    rst16 = 1'b1; start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0;

    // Reset with start held high must not launch anything
    repeat (2) @(negedge clk);
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_s", s8, 8'h00);
    check("rst_co", co8, 1'b0);
    check("rst_ovf", ovf8, 1'b0);
    rst8 = 1'b0; start8 = 1'b0; rst16 = 1'b0;
    @(negedge clk);
    check("rst_idle", busy8, 1'b0);

    op8("add_0f_01",    1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    op8("add_ff_01_c1", 1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0);
    op8("add_7f_01",    1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("add_80_80",    1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    op8("sub_05_07",    1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
    op8("sub_80_01",    1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
    op8("sub_05_02_b1", 1'b1, 8'h05, 8'h02, 1'b1, 8'h02, 1'b1, 1'b0);

    // Start and operand changes during RUN are ignored
    launch8(1'b0, 8'h3C, 8'h21, 1'b0);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h00; b8 = 8'hFF; sub8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'hAA; b8 = 8'h55;
    wait_done8("ignore", 6);
    check("ignore_s", s8, 8'h5D);
    check("ignore_co", co8, 1'b0);
    // Back-to-back: start accepted in the DONE cycle
    launch8(1'b1, 8'h10, 8'h01, 1'b0);
    check("b2b_busy", busy8, 1'b1);
    wait_done8("b2b", 8);
    check("b2b_s", s8, 8'h0F);
    check("b2b_co", co8, 1'b1);
    @(negedge clk);

    // Reset in the 4th RUN cycle aborts with no done
    launch8(1'b0, 8'h11, 8'h22, 1'b0);
    repeat (3) @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    check("abort_busy", busy8, 1'b0);
    check("abort_done", done8, 1'b0);
    check("abort_s", s8, 8'h00);
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (done8 || busy8) seen++;
      end
      check("abort_quiet", seen, 0);
    end

    // 16-bit, 4 bits per cycle
    begin
      int cycles;
      start16 = 1'b1; sub16 = 1'b0; a16 = 16'hFFFF; b16 = 16'h0001; ci16 = 1'b0;
      @(negedge clk);
      start16 = 1'b0;
      cycles = 0;
      while (!done16 && cycles < 40) begin
        @(negedge clk);
        cycles++;
      end
      check("w16_lat", cycles, 4);
      check("w16_s", s16, 16'h0000);
      check("w16_co", co16, 1'b1);
      check("w16_ovf", ovf16, 1'b0);

      // Back-to-back on the wide instance exercises carry into the top slice MSB
      start16 = 1'b1; a16 = 16'h7FFF; b16 = 16'h0001;
      @(negedge clk);
      start16 = 1'b0;
      cycles = 0;
      while (!done16 && cycles < 40) begin
        @(negedge clk);
        cycles++;
      end
      check("w16b_lat", cycles, 4);
      check("w16b_s", s16, 16'h8000);
      check("w16b_co", co16, 1'b0);
      check("w16b_ovf", ovf16, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
